membank_burst_ctrl: RTL and testbench
=====================================

# membank_burst_ctrl

Burst access controller for the node memory bank: the client side of the bank's 16-bit word port. It accepts a single command (base index, length, direction) and moves a run of consecutive 16-bit words between a valid/ready stream and the bank. Writes stream in from the routing/Q-table update logic; reads stream out to the neighbour-selection logic. It owns all bank index generation and keeps every access even-aligned.

## Interface
Parameters:
- WORD_WIDTH, 16, bank word width; each word is two bank bytes
- IDX_WIDTH, 6, bank byte-index width (64-byte bank)
- LEN_WIDTH, 5, burst length field width in words

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe; accepted only in IDLE
- rw  in  1  1 = write burst, 0 = read burst
- base_idx  in  IDX_WIDTH  starting byte index; bit 0 ignored (forced even)
- len  in  LEN_WIDTH  words to move; 0 encodes 32 (whole bank)
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse at burst completion
- s_data  in  WORD_WIDTH  write-stream word
- s_valid  in  1  write-stream valid
- s_ready  out  1  write-stream ready
- m_data  out  WORD_WIDTH  read-stream word (registered)
- m_valid  out  1  read-stream valid (registered)
- m_ready  in  1  read-stream ready
- mem_wr_en  out  1  bank write enable
- mem_index  out  IDX_WIDTH  bank byte index; always even
- mem_wdata  out  WORD_WIDTH  bank write data, {byte[idx], byte[idx+1]}
- mem_rdata  in  WORD_WIDTH  bank combinational read data for mem_index

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: when start=1, latch ptr={base_idx[5:1],0} and cnt=(len==0 ? 32 : len); go to WRITE if rw=1, else READ. When start=0, stay in IDLE.
- start outside IDLE is ignored. Command inputs are sampled only on acceptance.
- WRITE:
  - s_ready=1; mem_wr_en=s_valid; mem_wdata=s_data; mem_index=ptr.
  - On each s_valid&s_ready: ptr+=2, cnt-=1.
  - Handshake on the last word (cnt==1): go to DONE.
- READ:
  - mem_index=ptr.
  - When !m_valid or m_ready: m_data<=mem_rdata, m_valid<=1, ptr+=2, cnt-=1.
  - Capture of the last word: go to DRAIN.
- DRAIN:
  - Hold m_data/m_valid until m_ready; if m_ready, m_valid<=0, go to DONE.
  - The last word is not re-fetched.
- In READ, m_valid<=0 when m_ready=1 and no capture occurs. A capture always occurs in READ.
- DONE: done=1 for one cycle, then IDLE.
- Pointer arithmetic: ptr is IDX_WIDTH bits, +2 modulo 64, so 62 wraps to 0. ptr[0] is always 0, so idx+1 never exceeds 63.
- A 32-word burst from any base touches every word exactly once.
- mem_wr_en=0 in every state except WRITE. mem_index=ptr in all states.
- Reset (async, any time):
  - state=IDLE, ptr=0, cnt=0, m_valid=0, m_data=0.
  - Outputs: busy=0, done=0, s_ready=0, mem_wr_en=0.
  - Mid-burst reset abandons the burst. Words already written stay in the bank; no further write is issued.

## Timing
- Start accepted in cycle T. State is WRITE/READ and busy=1 from T+1.
- Write: one word per cycle while s_valid is held high. The bank updates on the edge ending the handshake cycle. done follows the last handshake by 1 cycle. An N-word burst with continuous s_valid has done at T+N+1.
- Read: first m_valid at T+2. With m_ready held high, one word per cycle. done is 1 cycle after the last word is consumed. An N-word burst has done at T+N+2.
- m_data/m_valid are stable while m_valid=1 and m_ready=0.
- s_ready is combinational from state only; there is no s_valid→s_ready path.

## Structure
- Shared package membank_pkg holds:
  - WORD_WIDTH, IDX_WIDTH, LEN_WIDTH, BANK_WORDS=32
  - the state enum (IDLE/WRITE/READ/DRAIN/DONE)
- Single module, no sub-module. The read output register is small enough to stay inline.
- The bench instantiates the node memory bank alongside, wiring mem_* to its port.

## Test plan
- Write base=0x04, len=3, words 0xA1B2, 0xC3D4, 0xE5F6, s_valid continuous → bytes 4..9 = A1,B2,C3,D4,E5,F6; done at T+4; mem_wr_en high exactly 3 cycles.
- Read back the same range with m_ready=1 → m_data 0xA1B2, 0xC3D4, 0xE5F6 on consecutive cycles from T+2; done at T+5.
- Read len=4, base=0x3C, m_ready toggled 1,0,0,1,… → indices 0x3C, 0x3E, 0x00, 0x02 (wrap); no word dropped or duplicated; m_data held while stalled.
- Write base=0x07 (odd), len=1, data 0x1234 → bytes 6,7 = 12,34; byte 8 untouched.
- Write len=0 with an incrementing pattern 0x0000..0x001F → all 32 words written once; done after the 32nd handshake; start pulsed mid-burst is ignored.
- Assert rst during the 2nd word of a 4-word write → mem_wr_en=0 immediately, busy=0, m_valid=0; word 1 persists; the next start runs normally.

Source files
------------

// File: rtl/membank_pkg.sv
// Shared widths and FSM state encoding for the node memory bank burst controller.
package membank_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int IDX_WIDTH  = 6;
    localparam int LEN_WIDTH  = 5;
    localparam int BANK_WORDS = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/membank_burst_ctrl.sv
// Burst controller between a valid/ready word stream and the 16-bit bank port.
// All bank indices come from ptr, which is kept even so idx+1 never leaves the bank.
module membank_burst_ctrl
    import membank_pkg::*;
#(
    parameter int WORD_WIDTH = membank_pkg::WORD_WIDTH,
    parameter int IDX_WIDTH  = membank_pkg::IDX_WIDTH,
    parameter int LEN_WIDTH  = membank_pkg::LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rw,
    input  logic [IDX_WIDTH-1:0]  base_idx,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  mem_wr_en,
    output logic [IDX_WIDTH-1:0]  mem_index,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    // One extra bit so the full-bank burst (len==0) fits as a plain count.
    localparam int CNT_W = LEN_WIDTH + 1;

    state_t               state;
    logic [IDX_WIDTH-1:0] ptr;
    logic [CNT_W-1:0]     cnt;
    logic                 capture;

    assign capture = (state == READ) && (!m_valid || m_ready);

    // NOTE: all state updates use <= so every register samples pre-edge values;
    // blocking assignments here would make ordering between statements matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: m_data is a single output register, not a memory, so it is
            // reset with the control state to give a defined value after reset.
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr   <= {base_idx[IDX_WIDTH-1:1], 1'b0};
                        cnt   <= (len == '0) ? CNT_W'(BANK_WORDS) : CNT_W'(len);
                        state <= rw ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (s_valid) begin
                        ptr <= ptr + IDX_WIDTH'(2);
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= DONE;
                    end
                end
                READ: begin
                    if (capture) begin
                        m_data  <= mem_rdata;
                        m_valid <= 1'b1;
                        ptr     <= ptr + IDX_WIDTH'(2);
                        cnt     <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last word is already held; wait for it to be taken, no re-fetch.
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status and handshake outputs decode the state register only.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign s_ready   = (state == WRITE);
    assign mem_wr_en = (state == WRITE) && s_valid;
    assign mem_index = ptr;
    assign mem_wdata = s_data;

endmodule

// File: tb/tb_membank_burst_ctrl.sv
// Directed bench for membank_burst_ctrl with a behavioural 64-byte bank on its port.
module tb_membank_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, rw;
    logic [5:0]  base_idx;
    logic [4:0]  len;
    logic        busy, done;
    logic [15:0] s_data;
    logic        s_valid, s_ready;
    logic [15:0] m_data;
    logic        m_valid, m_ready;
    logic        mem_wr_en;
    logic [5:0]  mem_index;
    logic [15:0] mem_wdata, mem_rdata;

    logic [7:0]  bank [0:63];

    int checks   = 0;
    int failures = 0;

    logic [15:0] wq [$];
    logic [15:0] got [$];

    always #5 clk = ~clk;

    membank_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rw        (rw),
        .base_idx  (base_idx),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .mem_wr_en (mem_wr_en),
        .mem_index (mem_index),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Node memory bank: big-endian word over two bytes at an even index.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            bank[mem_index]               <= mem_wdata[15:8];
            bank[{mem_index[5:1], 1'b1}]  <= mem_wdata[7:0];
        end
    end
    assign mem_rdata = {bank[mem_index], bank[{mem_index[5:1], 1'b1}]};

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    // Write burst from wq with continuous s_valid; optional ignored start pulse at pulse_cyc.
    task automatic run_write(input string tag, input logic [5:0] b, input logic [4:0] l,
                             input int exp_n, input int pulse_cyc);
        int cyc = 0, idx = 0, wr_cycles = 0, done_cyc = -1;
        logic hs;
        start = 1'b1; rw = 1'b1; base_idx = b; len = l;
        s_valid = 1'b1; s_data = wq[0];
        while (cyc < 100 && done_cyc < 0) begin
            @(negedge clk);
            if (mem_wr_en) wr_cycles++;
            if (done) done_cyc = cyc;
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            cyc++;
            start = (cyc == pulse_cyc);
            rw = 1'b0; base_idx = 6'h10; len = 5'd1;
            if (hs) begin
                idx++;
                if (idx < wq.size()) s_data = wq[idx];
                else s_valid = 1'b0;
            end
        end
        start = 1'b0; s_valid = 1'b0;
        check({tag, "_done_cyc"}, done_cyc, exp_n + 1);
        check({tag, "_wr_cycles"}, wr_cycles, exp_n);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    // Read burst; m_ready follows pat[cyc % 4]. Collects accepted words into got.
    task automatic run_read(input string tag, input logic [5:0] b, input logic [4:0] l,
                            input logic [3:0] pat, output int first_cyc, output int done_cyc);
        int cyc = 0, stall_err = 0;
        logic prev_hold = 1'b0;
        logic [15:0] prev_data = '0;
        first_cyc = -1; done_cyc = -1;
        got.delete();
        start = 1'b1; rw = 1'b0; base_idx = b; len = l;
        m_ready = pat[0];
        while (cyc < 200 && done_cyc < 0) begin
            @(negedge clk);
            if (m_valid && first_cyc < 0) first_cyc = cyc;
            if (prev_hold && m_data !== prev_data) stall_err++;
            if (m_valid && m_ready) got.push_back(m_data);
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            m_ready = pat[cyc % 4];
        end
        m_ready = 1'b0;
        check({tag, "_stall_hold"}, stall_err, 0);
    endtask

    int first_c, done_c;

    initial begin
        for (int i = 0; i < 64; i++) bank[i] = 8'hEE;
        rst = 1'b1; start = 1'b0; rw = 1'b0; base_idx = '0; len = '0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_wr_en",   mem_wr_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data",  m_data, 0);
        check("rst_index",   mem_index, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic 3-word write at 0x04.
        wq = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
        run_write("wr3", 6'h04, 5'd3, 3, -1);
        check("wr3_b4", bank[4], 8'hA1);
        check("wr3_b5", bank[5], 8'hB2);
        check("wr3_b6", bank[6], 8'hC3);
        check("wr3_b7", bank[7], 8'hD4);
        check("wr3_b8", bank[8], 8'hE5);
        check("wr3_b9", bank[9], 8'hF6);
        check("wr3_b3", bank[3], 8'hEE);

        // Read back with m_ready held high.
        @(posedge clk); #1;
        run_read("rd3", 6'h04, 5'd3, 4'b1111, first_c, done_c);
        check("rd3_first", first_c, 2);
        check("rd3_done",  done_c, 5);
        check("rd3_count", got.size(), 3);
        if (got.size() == 3) begin
            check("rd3_w0", got[0], 16'hA1B2);
            check("rd3_w1", got[1], 16'hC3D4);
            check("rd3_w2", got[2], 16'hE5F6);
        end

        // Odd base is forced even: 0x07 -> bytes 6,7.
        @(posedge clk); #1;
        wq = '{16'h1234};
        run_write("wrodd", 6'h07, 5'd1, 1, -1);
        check("wrodd_b6", bank[6], 8'h12);
        check("wrodd_b7", bank[7], 8'h34);
        check("wrodd_b8", bank[8], 8'hE5);

        // Wrapping write then stalled read at 0x3C.
        @(posedge clk); #1;
        wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_write("wrwrap", 6'h3C, 5'd4, 4, -1);
        check("wrwrap_b0", bank[0], 8'h33);
        check("wrwrap_b3", bank[3], 8'h44);
        @(posedge clk); #1;
        // pat bit i is m_ready when cyc%4==i: sequence 1,0,0,1
        run_read("rdwrap", 6'h3C, 5'd4, 4'b1001, first_c, done_c);
        check("rdwrap_done",  done_c, 9);
        check("rdwrap_count", got.size(), 4);
        if (got.size() == 4) begin
            check("rdwrap_w0", got[0], 16'h1111);
            check("rdwrap_w1", got[1], 16'h2222);
            check("rdwrap_w2", got[2], 16'h3333);
            check("rdwrap_w3", got[3], 16'h4444);
        end

        // Whole-bank write (len=0) from base 0x0A with an ignored start mid-burst.
        @(posedge clk); #1;
        wq.delete();
        for (int i = 0; i < 32; i++) wq.push_back(16'(i));
        run_write("wr32", 6'h0A, 5'd0, 32, 10);
        for (int i = 0; i < 32; i++) begin
            automatic int w = (5 + i) % 32;
            check($sformatf("wr32_w%0d", w), {bank[2*w], bank[2*w+1]}, 32'(i));
        end

        // Reset during the 2nd word of a 4-word write at 0x10.
        @(posedge clk); #1;
        start = 1'b1; rw = 1'b1; base_idx = 6'h10; len = 5'd4;
        s_valid = 1'b1; s_data = 16'hBEEF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        s_data = 16'hDEAD;
        @(negedge clk);
        check("rstmid_wr_before", mem_wr_en, 1);
        rst = 1'b1;
        #1;
        check("rstmid_wr_en",   mem_wr_en, 0);
        check("rstmid_busy",    busy, 0);
        check("rstmid_m_valid", m_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        check("rstmid_w1_hi", bank[16], 8'hBE);
        check("rstmid_w1_lo", bank[17], 8'hEF);
        check("rstmid_w2",    {bank[18], bank[19]}, 16'h0004);

        // Next command runs normally after the abandoned burst.
        wq = '{16'h5A5A, 16'hC0DE};
        run_write("wrpost", 6'h20, 5'd2, 2, -1);
        check("wrpost_w0", {bank[32], bank[33]}, 16'h5A5A);
        check("wrpost_w1", {bank[34], bank[35]}, 16'hC0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
